// File: rtl/rr_req_queue_pkg.sv
// Shared parameters, types and grant helpers for the
// per-requester request queue in front of the round-robin arbiter.
package rr_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int PTR_W   = $clog2(DEPTH);

    typedef logic [DATA_W-1:0]  rr_data_t;
    typedef logic [ID_W-1:0]    rr_id_t;
    typedef logic [CNT_W-1:0]   rr_cnt_t;
    typedef logic [PTR_W-1:0]   rr_ptr_t;
    typedef logic [NUM_REQ-1:0] rr_vec_t;

    function automatic logic is_onehot(rr_vec_t v);
        return (v != '0) && ((v & (v - rr_vec_t'(1))) == '0);
    endfunction

    function automatic rr_id_t onehot_idx(rr_vec_t v);
        rr_id_t idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) idx = rr_id_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_req_queue_if.sv
// Push / request / grant / output bundle of the request queue.
// master = requesters + arbiter + consumer, slave = the queue.
interface rr_req_queue_if;
    import rr_pkg::*;

    rr_vec_t                    push_i;
    logic [NUM_REQ*DATA_W-1:0]  push_data_i;
    rr_vec_t                    full_o;
    rr_vec_t                    req_o;
    rr_vec_t                    gnt_i;
    logic                       out_valid_o;
    rr_data_t                   out_data_o;
    rr_id_t                     out_id_o;
    logic                       err_o;

    modport master (
        output push_i, push_data_i, gnt_i,
        input  full_o, req_o, out_valid_o, out_data_o, out_id_o, err_o
    );

    modport slave (
        input  push_i, push_data_i, gnt_i,
        output full_o, req_o, out_valid_o, out_data_o, out_id_o, err_o
    );

endinterface

// File: rtl/rr_req_queue_fifo.sv
// Single synchronous FIFO with wrap-around pointers.
// A push while full is dropped even if a pop happens on the same edge.
module rr_fifo
    import rr_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push_i,
    input  logic     pop_i,
    input  rr_data_t data_i,
    output rr_data_t data_o,
    output rr_cnt_t  count_o,
    output logic     empty_o,
    output logic     full_o
);

    rr_data_t mem_q [DEPTH];
    rr_ptr_t  wptr_q, wptr_d;
    rr_ptr_t  rptr_q, rptr_d;
    rr_cnt_t  cnt_q, cnt_d;
    logic     do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == rr_cnt_t'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + rr_ptr_t'(1);
        if (do_pop)  rptr_d = rptr_q + rr_ptr_t'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + rr_cnt_t'(1);
            2'b01:   cnt_d = cnt_q - rr_cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (do_push) mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/rr_req_queue.sv
// Per-requester request queues feeding a 4-way round-robin arbiter;
// granted head is popped into a registered, ID-tagged output port.
module rr_req_queue
    import rr_pkg::*;
(
    input logic          clk,
    input logic          reset_n,
    rr_req_queue_if.slave bus
);

    rr_vec_t  full_w, empty_w, pop_w;
    rr_data_t head_w [NUM_REQ];
    rr_cnt_t  cnt_w  [NUM_REQ];

    logic     gnt_onehot, pop_vld, gnt_bad, ovf;
    rr_id_t   gnt_idx;

    logic     valid_q, valid_d;
    rr_data_t data_q, data_d;
    rr_id_t   id_q, id_d;
    logic     err_q, err_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        rr_fifo u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push_i  (bus.push_i[g]),
            .pop_i   (pop_w[g]),
            .data_i  (bus.push_data_i[g*DATA_W +: DATA_W]),
            .data_o  (head_w[g]),
            .count_o (cnt_w[g]),
            .empty_o (empty_w[g]),
            .full_o  (full_w[g])
        );
    end

    assign bus.req_o  = ~empty_w;
    assign bus.full_o = full_w;

    // A grant only pops when it is one-hot onto a non-empty queue.
    assign gnt_onehot = is_onehot(bus.gnt_i);
    assign gnt_idx    = onehot_idx(bus.gnt_i);
    assign pop_vld    = gnt_onehot && !empty_w[gnt_idx];
    assign gnt_bad    = (bus.gnt_i != '0) && !pop_vld;
    assign ovf        = |(bus.push_i & full_w);
    assign pop_w      = pop_vld ? bus.gnt_i : '0;

    always_comb begin
        valid_d = pop_vld;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q | gnt_bad | ovf;
        if (pop_vld) begin
            data_d = head_w[gnt_idx];
            id_d   = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid_o = valid_q;
    assign bus.out_data_o  = data_q;
    assign bus.out_id_o    = id_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_rr_req_queue.sv
// Directed vector table plus corner sequences and an
// arbiter-driven scoreboard run for rr_req_queue.
module tb_rr_req_queue;
    import rr_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    rr_req_queue_if bus ();

    rr_req_queue dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  push;
        logic [31:0] pdata;
        logic [3:0]  gnt;
        logic [3:0]  req;
        logic [3:0]  full;
        logic        vld;
        logic [7:0]  data;
        logic [1:0]  id;
        logic        err;
    } vec_t;

    vec_t vt [17];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] sb [4][$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.push_i      = '0;
        bus.push_data_i = '0;
        bus.gnt_i       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ptr;
        int gi;
        logic [3:0] pv;
        logic [31:0] pd;
        logic drained;
        logic [1:0] oid;

        vt[0]  = '{4'b0100, 32'h00A10000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
        vt[1]  = '{4'b0000, 32'h00000000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 8'hA1, 2'd2, 1'b0};
        vt[2]  = '{4'b0001, 32'h00000010, 4'b0000, 4'b0001, 4'b0000, 1'b0, 8'hA1, 2'd2, 1'b0};
        vt[3]  = '{4'b0001, 32'h00000011, 4'b0000, 4'b0001, 4'b0000, 1'b0, 8'hA1, 2'd2, 1'b0};
        vt[4]  = '{4'b0001, 32'h00000012, 4'b0000, 4'b0001, 4'b0000, 1'b0, 8'hA1, 2'd2, 1'b0};
        vt[5]  = '{4'b0001, 32'h00000013, 4'b0000, 4'b0001, 4'b0001, 1'b0, 8'hA1, 2'd2, 1'b0};
        vt[6]  = '{4'b0001, 32'h00000014, 4'b0000, 4'b0001, 4'b0001, 1'b0, 8'hA1, 2'd2, 1'b1};
        vt[7]  = '{4'b0000, 32'h00000000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'h10, 2'd0, 1'b1};
        vt[8]  = '{4'b0000, 32'h00000000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b1};
        vt[9]  = '{4'b0000, 32'h00000000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'h12, 2'd0, 1'b1};
        vt[10] = '{4'b0000, 32'h00000000, 4'b0001, 4'b0000, 4'b0000, 1'b1, 8'h13, 2'd0, 1'b1};
        vt[11] = '{4'b0000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h13, 2'd0, 1'b1};
        vt[12] = '{4'b0010, 32'h00002000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 8'h13, 2'd0, 1'b1};
        vt[13] = '{4'b0010, 32'h00002100, 4'b0000, 4'b0010, 4'b0000, 1'b0, 8'h13, 2'd0, 1'b1};
        vt[14] = '{4'b0010, 32'h00005500, 4'b0010, 4'b0010, 4'b0000, 1'b1, 8'h20, 2'd1, 1'b1};
        vt[15] = '{4'b0000, 32'h00000000, 4'b0010, 4'b0010, 4'b0000, 1'b1, 8'h21, 2'd1, 1'b1};
        vt[16] = '{4'b0000, 32'h00000000, 4'b0010, 4'b0000, 4'b0000, 1'b1, 8'h55, 2'd1, 1'b1};

        do_reset();
        chk("rst req", 32'(bus.req_o), 32'h0);
        chk("rst full", 32'(bus.full_o), 32'h0);
        chk("rst valid", 32'(bus.out_valid_o), 32'h0);
        chk("rst data", 32'(bus.out_data_o), 32'h0);
        chk("rst id", 32'(bus.out_id_o), 32'h0);
        chk("rst err", 32'(bus.err_o), 32'h0);

        for (int i = 0; i < 17; i++) begin
            bus.push_i      = vt[i].push;
            bus.push_data_i = vt[i].pdata;
            bus.gnt_i       = vt[i].gnt;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d req", i), 32'(bus.req_o), 32'(vt[i].req));
            chk($sformatf("v%0d full", i), 32'(bus.full_o), 32'(vt[i].full));
            chk($sformatf("v%0d valid", i), 32'(bus.out_valid_o), 32'(vt[i].vld));
            chk($sformatf("v%0d data", i), 32'(bus.out_data_o), 32'(vt[i].data));
            chk($sformatf("v%0d id", i), 32'(bus.out_id_o), 32'(vt[i].id));
            chk($sformatf("v%0d err", i), 32'(bus.err_o), 32'(vt[i].err));
        end
        idle_inputs();

        // non-one-hot grant with both queues loaded
        do_reset();
        bus.push_i      = 4'b0011;
        bus.push_data_i = 32'h00002211;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("ill2 req", 32'(bus.req_o), 32'h3);
        bus.gnt_i = 4'b0011;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("ill2 valid", 32'(bus.out_valid_o), 32'h0);
        chk("ill2 err", 32'(bus.err_o), 32'h1);
        chk("ill2 nopop", 32'(bus.req_o), 32'h3);

        // one-hot grant to an empty queue
        do_reset();
        bus.gnt_i = 4'b1000;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("empty gnt valid", 32'(bus.out_valid_o), 32'h0);
        chk("empty gnt err", 32'(bus.err_o), 32'h1);

        // random pushes arbitrated round-robin
        do_reset();
        ptr = 0;
        drained = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.out_valid_o) begin
                oid = bus.out_id_o;
                if (sb[oid].size() == 0) begin
                    chk("rnd unexpected", 32'(bus.out_data_o), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("rnd q%0d", oid), 32'(bus.out_data_o),
                        32'(sb[oid].pop_front()));
                end
            end
            if (c >= 32 && bus.req_o == '0) begin
                drained = 1'b1;
                break;
            end
            pv = (c < 32) ? (4'($urandom) & ~bus.full_o) : 4'b0000;
            pd = $urandom;
            for (int r = 0; r < 4; r++) begin
                if (pv[r]) sb[r].push_back(pd[r*8 +: 8]);
            end
            gi = -1;
            for (int k = 0; k < 4; k++) begin
                if (gi < 0 && bus.req_o[(ptr + k) % 4]) gi = (ptr + k) % 4;
            end
            bus.push_i      = pv;
            bus.push_data_i = pd;
            bus.gnt_i       = (gi >= 0) ? 4'(1 << gi) : 4'b0000;
            if (gi >= 0) ptr = (gi + 1) % 4;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        chk("rnd drained", 32'(drained), 32'h1);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("rnd left%0d", r), 32'(sb[r].size()), 32'h0);
        end
        chk("rnd err", 32'(bus.err_o), 32'h0);

        // asynchronous reset while entries are queued and popping
        do_reset();
        for (int j = 0; j < 4; j++) begin
            bus.push_i      = 4'b0100;
            bus.push_data_i = 32'(8'h30 + j) << 16;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        bus.gnt_i = 4'b0100;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("ar pre valid", 32'(bus.out_valid_o), 32'h1);
        chk("ar pre data", 32'(bus.out_data_o), 32'h30);
        chk("ar pre id", 32'(bus.out_id_o), 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar valid", 32'(bus.out_valid_o), 32'h0);
        chk("ar data", 32'(bus.out_data_o), 32'h0);
        chk("ar id", 32'(bus.out_id_o), 32'h0);
        chk("ar req", 32'(bus.req_o), 32'h0);
        chk("ar err", 32'(bus.err_o), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar post req", 32'(bus.req_o), 32'h0);
        chk("ar post valid", 32'(bus.out_valid_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_req_queue.md
# rr_req_queue

Per-requester request buffering stage directly upstream of the 4-way round-robin arbiter. Each requester pushes payload words into its own small FIFO; a non-empty FIFO raises the matching `req_o` bit into the arbiter, and the arbiter's one-hot grant pops that FIFO's head onto a single registered output port tagged with the requester ID. Overflow and illegal grants are flagged on a sticky error output.

## Interface
- `NUM_REQ`, 4, number of requesters (matches arbiter width)
- `DATA_W`, 8, payload width per entry
- `DEPTH`, 4, entries per FIFO; power of two, >= 2
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `push_i`  in  NUM_REQ  per-requester push strobe
- `push_data_i`  in  NUM_REQ*DATA_W  payload; requester i at bits [i*DATA_W +: DATA_W]
- `full_o`  out  NUM_REQ  FIFO i holds DEPTH entries
- `req_o`  out  NUM_REQ  FIFO i non-empty; drives arbiter `req_i`
- `gnt_i`  in  NUM_REQ  one-hot grant from arbiter `gnt_o`
- `out_valid_o`  out  1  popped entry valid this cycle
- `out_data_o`  out  DATA_W  popped payload
- `out_id_o`  out  $clog2(NUM_REQ)  index of the popped requester
- `err_o`  out  1  sticky error: overflow or illegal grant

## Operation
- One FIFO per requester, count 0..DEPTH, wrap-around read/write pointers (log2(DEPTH) bits).
- `req_o[i]` = count[i] != 0, combinational from registered count (no input paths).
- `full_o[i]` = count[i] == DEPTH, combinational from registered count.
- Push: `push_i[i]` && !full_o[i] writes data at write pointer, count+1. Push while full is dropped (even if a pop on the same FIFO occurs that edge), sets `err_o`.
- Pop: `gnt_i` exactly one-hot at bit k and `req_o[k]` = 1 -> head of FIFO k is read, count-1, registered to output.
- Simultaneous legal push and pop on the same FIFO: both occur, count unchanged; push into an empty FIFO is not poppable in the same cycle (req_o was 0).
- Illegal grant: `gnt_i` non-zero and not one-hot, or one-hot to an empty FIFO -> no pop, no output, `err_o` set. `gnt_i` = 0 is legal idle.
- `err_o` clears only on reset.
- No backpressure on the output port; consumer must accept every valid beat.

## Timing
- Reset (async assert, sync-to-clock deassert assumed by system): all counts/pointers 0, `req_o` 0, `full_o` 0, `out_valid_o` 0, `out_data_o` 0, `out_id_o` 0, `err_o` 0. Reset mid-operation discards all queued entries immediately.
- Push at edge N into empty FIFO -> `req_o[i]` high after edge N.
- Grant sampled at edge N -> `out_valid_o`, `out_data_o`, `out_id_o` valid after edge N for one cycle; `req_o`/`full_o` updated after the same edge.
- `out_valid_o` returns to 0 after the next edge unless another legal grant is sampled; `out_data_o`/`out_id_o` hold last value when not valid.
- Back-to-back grants to the same FIFO pop consecutive entries, one per cycle, FIFO order.

## Structure
- Package `rr_pkg`: `NUM_REQ`, `DATA_W`, `DEPTH`, `ID_W = $clog2(NUM_REQ)`, `CNT_W = $clog2(DEPTH)+1`, typedef `rr_data_t` (logic [DATA_W-1:0]), typedef `rr_id_t`.
- Sub-module `rr_fifo`: single synchronous FIFO (push, pop, data in/out, count, empty, full), instantiated NUM_REQ times via generate.
- Top: one-hot check, grant-to-index encoder, output register, error flag.

## Test plan
- Reset, push 0xA1 to requester 2 -> next cycle `req_o` = 4'b0100; `gnt_i` = 4'b0100 -> next cycle `out_valid_o`=1, `out_data_o`=0xA1, `out_id_o`=2, `req_o`=0.
- Push 0x10,0x11,0x12,0x13 to requester 0 -> `full_o[0]`=1; fifth push 0x14 -> dropped, `err_o`=1; four grants to bit 0 -> outputs 0x10..0x13 in order.
- Requester 1 holds 2 entries; same cycle push 0x55 and grant 4'b0010 -> count stays 2, oldest popped, 0x55 emerges last.
- `gnt_i` = 4'b0011 with both FIFOs non-empty -> no pop, `out_valid_o`=0, `err_o`=1; `gnt_i` = 4'b1000 with FIFO 3 empty -> same.
- Connect to the round-robin arbiter, 32 cycles random pushes (no overflow) -> every pushed word appears exactly once, per-requester order preserved, `err_o`=0.
- Assert `reset_n` low with 3 entries queued mid-pop -> outputs all 0 immediately, asynchronously; after release `req_o`=0.
